// File: rtl/stopwatch_timer.sv
// Stopwatch core: debounces three raw buttons, runs an idle/run/pause FSM and
// counts mm:ss from a prescaled clock, with a lap mode that freezes the display.
module stopwatch_timer #(
  parameter int CLOCK_HZ        = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop_btn,
  input  logic       clear_btn,
  input  logic       lap_btn,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       lap_active,
  output logic       second_tick
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PS_W = $clog2(CLOCK_HZ + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLOCK_HZ - 1);
  localparam int BTN_SS  = 0;
  localparam int BTN_CLR = 1;
  localparam int BTN_LAP = 2;

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

  state_t          state;
  logic [2:0]      raw_btn;
  logic [2:0]      sync_meta;
  logic [2:0]      sync_level;
  logic [2:0]      db_level;
  logic [2:0]      db_prev;
  logic [2:0]      press;
  logic [DB_W-1:0] stable_cnt [3];

  logic [PS_W-1:0] prescaler;
  logic [5:0]      cnt_sec;
  logic [5:0]      cnt_min;
  logic [5:0]      sec_inc;
  logic [5:0]      min_inc;
  logic [5:0]      live_sec;
  logic [5:0]      live_min;
  logic            sec_step;
  logic            clear_ok;
  logic            lap_next;

  assign raw_btn = {lap_btn, clear_btn, start_stop_btn};

  // Counter only runs while the synchronized level disagrees with the accepted one,
  // so any bounce back to the accepted level restarts the stability window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta  <= '0;
      sync_level <= '0;
      db_level   <= '0;
      db_prev    <= '0;
      press      <= '0;
      for (int i = 0; i < 3; i++) stable_cnt[i] <= '0;
    end else begin
      sync_meta  <= raw_btn;
      sync_level <= sync_meta;
      db_prev    <= db_level;
      press      <= db_level & ~db_prev;
      for (int i = 0; i < 3; i++) begin
        if (sync_level[i] == db_level[i]) begin
          stable_cnt[i] <= '0;
        end else if (stable_cnt[i] == DB_LAST) begin
          stable_cnt[i] <= '0;
          db_level[i]   <= sync_level[i];
        end else begin
          stable_cnt[i] <= stable_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sec_step = (state == RUNNING) && (prescaler == PS_LAST);
    sec_inc  = (cnt_sec == 6'd59) ? 6'd0 : cnt_sec + 6'd1;
    min_inc  = cnt_min;
    if (cnt_sec == 6'd59) min_inc = (cnt_min == 6'd59) ? 6'd0 : cnt_min + 6'd1;
    live_sec = sec_step ? sec_inc : cnt_sec;
    live_min = sec_step ? min_inc : cnt_min;
    clear_ok = press[BTN_CLR] && (state != RUNNING);
    lap_next = lap_active;
    if (press[BTN_LAP]) begin
      if (state == RUNNING)     lap_next = ~lap_active;
      else if (state == PAUSED) lap_next = 1'b0;
    end
  end

  // An accepted clear swallows same-cycle start_stop and lap presses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      running     <= 1'b0;
      lap_active  <= 1'b0;
      second_tick <= 1'b0;
      prescaler   <= '0;
      cnt_sec     <= '0;
      cnt_min     <= '0;
      seconds     <= '0;
      minutes     <= '0;
    end else begin
      second_tick <= 1'b0;
      if (clear_ok) begin
        state      <= IDLE;
        running    <= 1'b0;
        lap_active <= 1'b0;
        prescaler  <= '0;
        cnt_sec    <= '0;
        cnt_min    <= '0;
        seconds    <= '0;
        minutes    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (press[BTN_SS]) begin
              state   <= RUNNING;
              running <= 1'b1;
            end
          end
          RUNNING: begin
            if (press[BTN_SS]) begin
              state   <= PAUSED;
              running <= 1'b0;
            end
          end
          PAUSED: begin
            if (press[BTN_SS]) begin
              state   <= RUNNING;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase

        if (state == RUNNING) begin
          if (sec_step) begin
            prescaler   <= '0;
            cnt_sec     <= sec_inc;
            cnt_min     <= min_inc;
            second_tick <= 1'b1;
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end

        // Display holds whatever it showed when lap was set; it rejoins the live count on release.
        lap_active <= lap_next;
        if (!lap_next) begin
          seconds <= live_sec;
          minutes <= live_min;
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed self-checking bench for stopwatch_timer with CLOCK_HZ=10, DEBOUNCE_CYCLES=4.
// A full press held from a negedge takes effect on the 8th following rising edge.
module tb_stopwatch_timer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_stop_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic       lap_btn = 1'b0;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       lap_active;
  logic       second_tick;

  int errors = 0;
  int checks = 0;
  int ticks  = 0;

  localparam logic [2:0] SS  = 3'b001;
  localparam logic [2:0] CLR = 3'b010;
  localparam logic [2:0] LAP = 3'b100;

  stopwatch_timer #(
    .CLOCK_HZ(10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_stop_btn(start_stop_btn),
    .clear_btn(clear_btn),
    .lap_btn(lap_btn),
    .minutes(minutes),
    .seconds(seconds),
    .running(running),
    .lap_active(lap_active),
    .second_tick(second_tick)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_output(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_time(input string tag, input int mm, input int ss);
    check_val({tag, "_min"}, int'(minutes), mm);
    check_val({tag, "_sec"}, int'(seconds), ss);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge clock);
      if (second_tick) ticks++;
    end
  endtask

  // Hold the selected buttons for eight cycles from a negedge, then release them.
  task automatic apply_stimulus(input logic [2:0] mask);
    start_stop_btn = mask[0];
    clear_btn      = mask[1];
    lap_btn        = mask[2];
    wait_cycles(8);
    start_stop_btn = 1'b0;
    clear_btn      = 1'b0;
    lap_btn        = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    check_time("reset", 0, 0);
    check_output("reset_running", running, 1'b0);
    check_output("reset_lap", lap_active, 1'b0);
    check_output("reset_tick", second_tick, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] glitch rejection and press latency");
    start_stop_btn = 1'b1;
    repeat (3) @(negedge clock);
    start_stop_btn = 1'b0;
    wait_cycles(12);
    check_output("glitch_running", running, 1'b0);
    start_stop_btn = 1'b1;
    wait_cycles(7);
    check_output("latency_early", running, 1'b0);
    wait_cycles(1);
    check_output("latency_on", running, 1'b1);
    start_stop_btn = 1'b0;

    $display("[TB] minute rollover and 59:59 wrap");
    ticks = 0;
    wait_cycles(590);
    check_time("t590", 0, 59);
    wait_cycles(10);
    check_time("t600", 1, 0);
    check_output("t600_tick", second_tick, 1'b1);
    check_val("t600_ticks", ticks, 60);
    wait_cycles(35390);
    check_time("t35990", 59, 59);
    wait_cycles(10);
    check_time("wrap", 0, 0);
    check_output("wrap_tick", second_tick, 1'b1);
    check_val("wrap_ticks", ticks, 3600);

    $display("[TB] pause holds prescaler");
    do_reset();
    apply_stimulus(SS);
    wait_cycles(7);
    apply_stimulus(SS);
    check_output("paused_running", running, 1'b0);
    check_time("paused", 0, 1);
    ticks = 0;
    wait_cycles(100);
    check_time("paused_hold", 0, 1);
    check_val("paused_ticks", ticks, 0);
    apply_stimulus(SS);
    check_output("resume_running", running, 1'b1);
    wait_cycles(4);
    check_output("resume_no_tick", second_tick, 1'b0);
    check_time("resume_pre", 0, 1);
    wait_cycles(1);
    check_output("resume_tick", second_tick, 1'b1);
    check_time("resume_post", 0, 2);

    $display("[TB] lap freeze and release");
    do_reset();
    apply_stimulus(SS);
    wait_cycles(45);
    check_time("lap_before", 0, 4);
    apply_stimulus(LAP);
    check_output("lap_set", lap_active, 1'b1);
    check_time("lap_set", 0, 5);
    ticks = 0;
    wait_cycles(62);
    check_val("lap_ticks", ticks, 6);
    check_time("lap_frozen", 0, 5);
    apply_stimulus(LAP);
    check_output("lap_release", lap_active, 1'b0);
    check_time("lap_release", 0, 12);
    wait_cycles(7);
    check_time("lap_live", 0, 13);
    check_output("lap_live_tick", second_tick, 1'b1);

    $display("[TB] clear handling");
    do_reset();
    apply_stimulus(SS);
    wait_cycles(25);
    apply_stimulus(CLR);
    check_output("clr_run_ignored", running, 1'b1);
    check_time("clr_run_ignored", 0, 3);
    wait_cycles(2);
    apply_stimulus(SS);
    check_output("clr_paused", running, 1'b0);
    check_time("clr_paused", 0, 4);
    wait_cycles(12);
    apply_stimulus(SS | CLR);
    check_output("clr_accept_running", running, 1'b0);
    check_time("clr_accept", 0, 0);
    wait_cycles(20);
    check_output("clr_idle_running", running, 1'b0);
    check_time("clr_idle", 0, 0);
    apply_stimulus(SS);
    wait_cycles(9);
    check_time("clr_ps_zero", 0, 0);
    wait_cycles(1);
    check_time("clr_first_tick", 0, 1);

    $display("[TB] asynchronous reset mid-run");
    do_reset();
    apply_stimulus(SS);
    wait_cycles(65);
    apply_stimulus(LAP);
    check_output("rst_pre_lap", lap_active, 1'b1);
    check_time("rst_pre", 0, 7);
    wait_cycles(2);
    #2;
    reset = 1'b1;
    #1;
    check_time("rst_async", 0, 0);
    check_output("rst_async_running", running, 1'b0);
    check_output("rst_async_lap", lap_active, 1'b0);
    check_output("rst_async_tick", second_tick, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    wait_cycles(20);
    check_output("rst_idle_running", running, 1'b0);
    check_time("rst_idle", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
